instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding imem requester feeding a small in-order instruction buffer.
// Build option FETCH_MISALIGN_CHK_EN: misaligned redirects raise sticky misalign_err instead of being masked.
//
// state | meaning
// IDLE  | no request: buffer plus in-flight is full, or parked on a misaligned redirect
// REQ   | imem_req asserted at fetch_pc, waiting for gnt
// WAIT  | one request outstanding, its response is written to the buffer tail
// DROP  | one request outstanding whose response belongs to a squashed path
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instr,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic        misalign_err
);
   localparam int PTR_W = $clog2(BUF_DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(BUF_DEPTH);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
`ifdef FETCH_MISALIGN_CHK_EN
   localparam logic CHK_EN = 1'b1;
`else
   localparam logic CHK_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

   state_t           state_q, state_d;
   logic [31:0]      fetch_pc_q, fetch_pc_d;
   logic [31:0]      buf_instr_q [BUF_DEPTH];
   logic [31:0]      buf_instr_d [BUF_DEPTH];
   logic [31:0]      buf_pc_q    [BUF_DEPTH];
   logic [31:0]      buf_pc_d    [BUF_DEPTH];
   logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             misalign_q, misalign_d;

   logic             redir_bad;
   logic [31:0]      redir_pc;
   logic             deq;

   assign redir_bad = CHK_EN & (|redirect_pc[1:0]);
   assign redir_pc  = CHK_EN ? redirect_pc : {redirect_pc[31:2], 2'b00};
   assign deq       = (count_q != '0) && instr_ready;

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      misalign_d  = misalign_q;
      if (redirect_valid) begin
         // Redirect wins: flush, retarget, and keep tracking any response still owed to us.
         head_d     = '0;
         tail_d     = '0;
         count_d    = '0;
         fetch_pc_d = redir_pc;
         misalign_d = redir_bad;
         case (state_q)
            IDLE:    state_d = redir_bad ? IDLE : REQ;
            REQ:     state_d = imem_gnt ? DROP : (redir_bad ? IDLE : REQ);
            WAIT:    state_d = imem_rvalid ? (redir_bad ? IDLE : REQ) : DROP;
            DROP:    state_d = imem_rvalid ? (redir_bad ? IDLE : REQ) : DROP;
            default: state_d = IDLE;
         endcase
      end else begin
         if (deq) begin
            head_d  = head_q + PTR_ONE;
            count_d = count_q - CNT_ONE;
         end
         case (state_q)
            IDLE: begin
               if (!misalign_q && (count_q < DEPTH_C)) state_d = REQ;
            end
            REQ: begin
               if (imem_gnt) begin
                  state_d    = WAIT;
                  fetch_pc_d = fetch_pc_q + 32'd4;
               end
            end
            WAIT: begin
               if (imem_rvalid) begin
                  // fetch_pc already advanced at gnt, so the entry's address is one word back.
                  buf_instr_d[tail_q] = imem_rdata;
                  buf_pc_d[tail_q]    = fetch_pc_q - 32'd4;
                  tail_d              = tail_q + PTR_ONE;
                  count_d             = count_d + CNT_ONE;
                  state_d             = (count_d < DEPTH_C) ? REQ : IDLE;
               end
            end
            DROP: begin
               if (imem_rvalid) state_d = misalign_q ? IDLE : REQ;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         misalign_q <= 1'b0;
         for (int i = 0; i < BUF_DEPTH; i++) begin
            buf_instr_q[i] <= '0;
            buf_pc_q[i]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         misalign_q  <= misalign_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
      end
   end

   assign imem_req     = (state_q == REQ);
   assign imem_addr    = fetch_pc_q;
   assign Instr        = buf_instr_q[head_q];
   assign PC           = buf_pc_q[head_q];
   assign PCPlus4      = PC + 32'd4;
   assign instr_valid  = (count_q != '0);
   assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized memory/decode/redirect environment
// checked against an instruction-stream scoreboard.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam int          DEPTH  = 2;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic [31:0] Instr;
   logic [31:0] PC;
   logic [31:0] PCPlus4;
   logic        instr_valid;
   logic        instr_ready;
   logic        misalign_err;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RST_PC), .BUF_DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .Instr(Instr), .PC(PC), .PCPlus4(PCPlus4),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .misalign_err(misalign_err)
   );

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Environment / scoreboard state
   typedef struct { logic [31:0] addr; int dly; } pend_t;
   pend_t       pend_q[$];
   logic [31:0] exp_pc, exp_fetch, grant_addr, last_addr, last_pc, last_instr;
   bit          last_g, last_redir, last_hold, last_stall_req;
   int          deq_count, first_valid_cyc, eng_cyc;

   task automatic engine_init();
      pend_q.delete();
      exp_pc = RST_PC; exp_fetch = RST_PC;
      last_g = 0; last_redir = 0; last_hold = 0; last_stall_req = 0;
      grant_addr = '0; last_addr = '0; last_pc = '0; last_instr = '0;
      deq_count = 0; first_valid_cyc = -1; eng_cyc = 1;
   endtask

   task automatic do_reset();
      rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_gnt = 0;
      imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
      step(); step();
      rst_n = 1;
      step();
      engine_init();
   endtask

   // One cycle of randomized environment: observe, check, choose inputs, advance.
   task automatic engine_cycle(input int gnt_pct, input int lat_max, input int rdy_pct, input int redir_pct);
      pend_t p;
      bit g, rv, rdy, rd;
      logic [31:0] rpc, tgt;
      if (last_g) begin
         p.addr = grant_addr; p.dly = int'($urandom_range(lat_max, 0));
         pend_q.push_back(p);
      end
      if (last_redir) begin
         tests_run++;
         if (instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_after_redirect: valid=%b err=%b, expected valid=0 err=0", instr_valid, misalign_err);
         end
      end
      if (last_hold) begin
         tests_run++;
         if (instr_valid !== 1'b1 || PC !== last_pc || Instr !== last_instr) begin
            tests_failed++;
            $display("FAIL head_stable: valid=%b PC=%h Instr=%h, expected valid=1 PC=%h Instr=%h",
                     instr_valid, PC, Instr, last_pc, last_instr);
         end
      end
      if (last_stall_req) begin
         tests_run++;
         if (imem_req !== 1'b1 || imem_addr !== last_addr) begin
            tests_failed++;
            $display("FAIL addr_hold: req=%b addr=%h, expected req=1 addr=%h", imem_req, imem_addr, last_addr);
         end
      end
      if (pend_q.size() != 0) begin
         tests_run++;
         if (imem_req !== 1'b0) begin
            tests_failed++;
            $display("FAIL one_outstanding: req=%b with response pending, expected req=0", imem_req);
         end
      end
      if (instr_valid === 1'b1 && first_valid_cyc < 0) first_valid_cyc = eng_cyc;

      rv = 0; imem_rdata = '0;
      if (pend_q.size() != 0) begin
         p = pend_q[0];
         if (p.dly == 0) begin
            rv = 1; imem_rdata = mem_word(p.addr);
            void'(pend_q.pop_front());
         end else begin
            p.dly = p.dly - 1; pend_q[0] = p;
         end
      end

      rdy = ($urandom_range(99, 0) < rdy_pct);
      rd  = ($urandom_range(99, 0) < redir_pct);
      g   = (imem_req === 1'b1) && ($urandom_range(99, 0) < gnt_pct);

      if (g) begin
         tests_run++;
         if (imem_addr !== exp_fetch || (exp_fetch - exp_pc) >= 32'(4*DEPTH)) begin
            tests_failed++;
            $display("FAIL grant_addr: addr=%h in_flight=%0d, expected addr=%h in_flight<%0d",
                     imem_addr, (exp_fetch - exp_pc) >> 2, exp_fetch, DEPTH);
         end
         grant_addr = imem_addr;
         exp_fetch  = exp_fetch + 32'd4;
      end
      if (instr_valid === 1'b1 && rdy && !rd) begin
         tests_run++;
         if (PC !== exp_pc || Instr !== mem_word(exp_pc) || PCPlus4 !== exp_pc + 32'd4) begin
            tests_failed++;
            $display("FAIL dequeue: PC=%h Instr=%h PCPlus4=%h, expected PC=%h Instr=%h PCPlus4=%h",
                     PC, Instr, PCPlus4, exp_pc, mem_word(exp_pc), exp_pc + 32'd4);
         end
         exp_pc = exp_pc + 32'd4;
         deq_count++;
      end
      rpc = $urandom();
      if (rd) begin
         if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_MISALIGN_CHK_EN
         rpc[1:0] = 2'b00;
         tgt = rpc;
`else
         if ($urandom_range(3, 0) != 0) rpc[1:0] = 2'b00;
         tgt = {rpc[31:2], 2'b00};
`endif
         exp_pc = tgt; exp_fetch = tgt;
      end

      imem_gnt = g; imem_rvalid = rv; instr_ready = rdy;
      redirect_valid = rd; redirect_pc = rpc;
      last_g = g; last_redir = rd;
      last_hold = (instr_valid === 1'b1) && !rdy && !rd;
      last_pc = PC; last_instr = Instr;
      last_stall_req = (imem_req === 1'b1) && !g && !rd;
      last_addr = imem_addr;
      step();
      eng_cyc++;
   endtask

   task automatic test_reset();
      rst_n = 0; redirect_valid = 0; redirect_pc = '0; imem_gnt = 0;
      imem_rvalid = 0; imem_rdata = '0; instr_ready = 0;
      step(); step();
      tests_run++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0 || misalign_err !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_outputs: req=%b valid=%b err=%b, expected 0 0 0", imem_req, instr_valid, misalign_err);
      end
      rst_n = 1;
      step();
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL first_request: req=%b addr=%h valid=%b, expected req=1 addr=%h valid=0",
                  imem_req, imem_addr, instr_valid, RST_PC);
      end
      engine_init();
   endtask

   task automatic test_stream();
      for (int i = 0; i < 20; i++) engine_cycle(100, 0, 100, 0);
      tests_run++;
      if (first_valid_cyc != 3 || deq_count != 9) begin
         tests_failed++;
         $display("FAIL stream_timing: first_valid=%0d dequeues=%0d, expected 3 and 9", first_valid_cyc, deq_count);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      for (int i = 0; i < 10; i++) engine_cycle(100, 0, 0, 0);
      tests_run++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b1 || PC !== RST_PC || (exp_fetch - RST_PC) !== 32'(4*DEPTH)) begin
         tests_failed++;
         $display("FAIL backpressure_fill: req=%b valid=%b PC=%h fetched=%0d, expected req=0 valid=1 PC=%h fetched=%0d",
                  imem_req, instr_valid, PC, (exp_fetch - RST_PC) >> 2, RST_PC, DEPTH);
      end
      for (int i = 0; i < 12; i++) engine_cycle(100, 0, 100, 0);
      tests_run++;
      if (deq_count < DEPTH + 2) begin
         tests_failed++;
         $display("FAIL backpressure_resume: dequeues=%0d, expected at least %0d", deq_count, DEPTH + 2);
      end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      imem_gnt = 1; step();
      imem_gnt = 0; redirect_valid = 1; redirect_pc = 32'h0000_0100; step();
      redirect_valid = 0;
      tests_run++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL redirect_wait_drop: req=%b valid=%b, expected 0 0", imem_req, instr_valid);
      end
      imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF; step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0000_0100) begin
         tests_failed++;
         $display("FAIL redirect_wait_refetch: valid=%b req=%b addr=%h, expected 0 1 00000100", instr_valid, imem_req, imem_addr);
      end
      imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'h0000_0100); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== 32'h0000_0100 || Instr !== mem_word(32'h0000_0100)) begin
         tests_failed++;
         $display("FAIL redirect_wait_head: valid=%b PC=%h Instr=%h, expected 1 00000100 %h",
                  instr_valid, PC, Instr, mem_word(32'h0000_0100));
      end
   endtask

   task automatic test_redirect_req();
      do_reset();
      redirect_valid = 1; redirect_pc = 32'h0000_0200; step();
      redirect_valid = 0;
      tests_run++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h0000_0200) begin
         tests_failed++;
         $display("FAIL redirect_req_retarget: req=%b addr=%h, expected 1 00000200", imem_req, imem_addr);
      end
      step();
      imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'h0000_0200); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== 32'h0000_0200 || Instr !== mem_word(32'h0000_0200)) begin
         tests_failed++;
         $display("FAIL redirect_req_head: valid=%b PC=%h Instr=%h, expected 1 00000200 %h",
                  instr_valid, PC, Instr, mem_word(32'h0000_0200));
      end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1; redirect_pc = 32'hFFFF_FFFC; step();
      redirect_valid = 0; imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'hFFFF_FFFC); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== 32'hFFFF_FFFC || PCPlus4 !== 32'h0 || imem_addr !== 32'h0) begin
         tests_failed++;
         $display("FAIL wrap_first: valid=%b PC=%h PCPlus4=%h addr=%h, expected 1 fffffffc 00000000 00000000",
                  instr_valid, PC, PCPlus4, imem_addr);
      end
      instr_ready = 1; imem_gnt = 1; step();
      instr_ready = 0; imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(32'h0); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== 32'h0 || PCPlus4 !== 32'h4 || Instr !== mem_word(32'h0)) begin
         tests_failed++;
         $display("FAIL wrap_second: valid=%b PC=%h PCPlus4=%h Instr=%h, expected 1 00000000 00000004 %h",
                  instr_valid, PC, PCPlus4, Instr, mem_word(32'h0));
      end
   endtask

   task automatic test_misalign();
      logic [31:0] good;
      do_reset();
      redirect_valid = 1; redirect_pc = 32'h0000_0102; step();
      redirect_valid = 0;
`ifdef FETCH_MISALIGN_CHK_EN
      step(); step();
      tests_run++;
      if (misalign_err !== 1'b1 || imem_req !== 1'b0) begin
         tests_failed++;
         $display("FAIL misalign_park: err=%b req=%b, expected 1 0", misalign_err, imem_req);
      end
      redirect_valid = 1; redirect_pc = 32'h0000_0104; step();
      redirect_valid = 0;
      good = 32'h0000_0104;
`else
      good = 32'h0000_0100;
`endif
      tests_run++;
      if (misalign_err !== 1'b0 || imem_req !== 1'b1 || imem_addr !== good) begin
         tests_failed++;
         $display("FAIL misalign_fetch: err=%b req=%b addr=%h, expected 0 1 %h", misalign_err, imem_req, imem_addr, good);
      end
      imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(good); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== good) begin
         tests_failed++;
         $display("FAIL misalign_head: valid=%b PC=%h, expected 1 %h", instr_valid, PC, good);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      imem_gnt = 1; step();
      imem_gnt = 0; rst_n = 0; step();
      tests_run++;
      if (imem_req !== 1'b0 || instr_valid !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_mid_outputs: req=%b valid=%b, expected 0 0", imem_req, instr_valid);
      end
      rst_n = 1; imem_rvalid = 1; imem_rdata = 32'h0BAD_0BAD; step();
      step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== RST_PC) begin
         tests_failed++;
         $display("FAIL reset_mid_stale: valid=%b req=%b addr=%h, expected 0 1 %h", instr_valid, imem_req, imem_addr, RST_PC);
      end
      imem_gnt = 1; step();
      imem_gnt = 0; imem_rvalid = 1; imem_rdata = mem_word(RST_PC); step();
      imem_rvalid = 0;
      tests_run++;
      if (instr_valid !== 1'b1 || PC !== RST_PC || Instr !== mem_word(RST_PC)) begin
         tests_failed++;
         $display("FAIL reset_mid_refetch: valid=%b PC=%h Instr=%h, expected 1 %h %h",
                  instr_valid, PC, Instr, RST_PC, mem_word(RST_PC));
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 3000; i++) engine_cycle(60, 3, 60, 3);
      for (int i = 0; i < 600; i++) engine_cycle(100, 0, 30, 1);
      tests_run++;
      if (deq_count < 100) begin
         tests_failed++;
         $display("FAIL random_progress: dequeues=%0d, expected at least 100", deq_count);
      end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_req();
      test_wrap();
      test_misalign();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
